// File: rtl/mem_arb_pkg.sv
// Shared types, default parameters and helpers for the memory arbiter.
package mem_arb_pkg;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;
  localparam int LAT_CW         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    arb_state_e        state;
    owner_e            owner;
    logic              we;
    logic [LAT_CW-1:0] lat_cnt;
  } arb_dbg_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory port seen by the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  import mem_arb_pkg::*;

  // Handshake: a requester raises *_req with stable address/data/we and holds
  // it until its one-cycle *_gnt; a read then returns exactly one *_rvalid
  // pulse. Memory sees one m_read or m_write strobe per access and must
  // present m_rdata MEM_LAT cycles after the m_read cycle.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_rdata;

  logic          busy;
  arb_dbg_t      dbg;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output m_addr, m_wdata, m_read, m_write, busy, dbg
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_wdata, m_read, m_write, busy, dbg
  );

endinterface

// File: rtl/arb_prio.sv
// Winner selection: data first, unless a fetch has waited through STARVE_MAX data grants.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int CW         = cnt_width(DEF_STARVE_MAX)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          sel_data
);

  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  always_comb begin
    sel_data = d_req && !(if_req && (starve_cnt == STARVE_TOP));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory,
// one access outstanding at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int                SCW        = cnt_width(STARVE_MAX);
  localparam logic [LAT_CW-1:0] LAT_LAST   = LAT_CW'(MEM_LAT - 1);
  localparam logic [SCW-1:0]    STARVE_TOP = SCW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [LAT_CW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;

  logic sel_data;
  logic any_req;
  logic wait_done;

  arb_prio #(
    .STARVE_MAX(STARVE_MAX),
    .CW        (SCW)
  ) u_prio (
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .starve_cnt(starve_cnt_q),
    .sel_data  (sel_data)
  );

  assign any_req   = bus.if_req | bus.d_req;
  // Last WAIT cycle is the one in which memory presents the read word.
  assign wait_done = (state_q == ST_WAIT) && (lat_cnt_q == LAT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: begin
        lat_cnt_d = '0;
        state_d   = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_done) begin
          lat_cnt_d = '0;
          state_d   = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_CW'(1);
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pulses are computed one cycle ahead so every strobe leaves a flop.
  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_read_d     = 1'b0;
    m_write_d    = 1'b0;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;

    if ((state_q == ST_IDLE) && any_req) begin
      owner_d   = sel_data ? OWN_D : OWN_IF;
      we_d      = sel_data & bus.d_we;
      m_addr_d  = sel_data ? bus.d_addr : bus.if_addr;
      m_wdata_d = sel_data ? bus.d_wdata : '0;
      m_read_d  = ~(sel_data & bus.d_we);
      m_write_d = sel_data & bus.d_we;
      if_gnt_d  = ~sel_data;
      d_gnt_d   = sel_data;
    end

    if (wait_done) begin
      if (owner_q == OWN_D) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = bus.m_rdata;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = bus.m_rdata;
      end
    end

    if (if_gnt_q) begin
      starve_cnt_d = '0;
    end else if (d_gnt_q && bus.if_req && (starve_cnt_q != STARVE_TOP)) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end else if ((state_q == ST_IDLE) && !bus.if_req) begin
      starve_cnt_d = '0;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_read    = m_read_q;
  assign bus.m_write   = m_write_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg       = '{state: state_q, owner: owner_q, we: we_q, lat_cnt: lat_cnt_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, scoreboard queue, multi-cycle sequences, latency sweep.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam logic [DW-1:0] GARBAGE = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C02_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: word valid only in the cycle MEM_LAT after the m_read cycle.
  logic [AW-1:0] rd_addr;
  int            rd_cnt = 0;
  always begin
    @(posedge clk); #1;
    bus.m_rdata = (rd_cnt == 1) ? mem_read(rd_addr) : GARBAGE;
    if (rd_cnt > 0) rd_cnt--;
    @(negedge clk);
    if (!rst && bus.m_read) begin
      rd_addr = bus.m_addr;
      rd_cnt  = LAT;
    end
  end

  // Scoreboard
  logic [DW:0]      exp_q[$];
  logic [AW+DW-1:0] wexp_q[$];
  logic [DW:0]      e;
  logic [DW-1:0]    last_if = '0;
  logic [DW-1:0]    last_d  = '0;
  bit               rd_out  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      last_if = '0;
      last_d  = '0;
      rd_out  = 1'b0;
    end else begin
      if (bus.if_gnt || bus.d_gnt) begin
        check("one_gnt", 64'(bus.if_gnt & bus.d_gnt), 64'd0);
        check("if_rdata_hold", 64'(bus.if_rdata), 64'(last_if));
        check("d_rdata_hold", 64'(bus.d_rdata), 64'(last_d));
      end
      if (bus.m_read || bus.m_write || bus.if_gnt || bus.d_gnt) begin
        check("strobe_excl", 64'(bus.m_read & bus.m_write), 64'd0);
        check("strobe_with_gnt", 64'(bus.m_read | bus.m_write), 64'(bus.if_gnt | bus.d_gnt));
      end
      if (bus.m_read) begin
        check("read_overlap", 64'(rd_out), 64'd0);
        rd_out = 1'b1;
      end
      if (bus.m_write) begin
        check("write_expected", 64'(wexp_q.size() != 0), 64'd1);
        if (wexp_q.size() != 0) check("write_bus", {bus.m_addr, bus.m_wdata}, 64'(wexp_q.pop_front()));
      end
      if (bus.if_rvalid || bus.d_rvalid) begin
        rd_out = 1'b0;
        check("one_rvalid", 64'(bus.if_rvalid & bus.d_rvalid), 64'd0);
        check("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rvalid_owner", 64'(bus.d_rvalid), 64'(e[DW]));
          if (e[DW]) begin
            last_d = e[DW-1:0];
            check("d_rdata", 64'(bus.d_rdata), 64'(last_d));
          end else begin
            last_if = e[DW-1:0];
            check("if_rdata", 64'(bus.if_rdata), 64'(last_if));
          end
        end
      end
    end
  end

  // Driver: one access, cycle 1 = first cycle the request is presented.
  task automatic do_req(input bit is_d, input bit we, input bit early,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output int gnt_cyc, output int end_cyc);
    int cyc;
    bit done;
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    if (we) wexp_q.push_back({addr, wdata});
    else    exp_q.push_back({is_d, mem_read(addr)});
    cyc = 1; gnt_cyc = 0; end_cyc = 0; done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if ((is_d ? bus.d_gnt : bus.if_gnt) && gnt_cyc == 0) gnt_cyc = cyc;
      if (we && gnt_cyc != 0 && cyc == gnt_cyc + 1) begin
        end_cyc = cyc;
        check("busy_after_write", 64'(bus.busy), 64'd0);
        done = 1'b1;
      end else if (!we && (is_d ? bus.d_rvalid : bus.if_rvalid)) begin
        end_cyc = cyc;
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
        if (gnt_cyc != 0 || early) begin
          if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        end
      end
    end
    if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_strobes"}, 64'({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                                  bus.m_read, bus.m_write}), 64'd0);
    check({tag, "_m_addr"}, 64'(bus.m_addr), 64'd0);
    check({tag, "_m_wdata"}, 64'(bus.m_wdata), 64'd0);
    check({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    check({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
  endtask

  // Latency sweep: one DUT per MEM_LAT value, each with its own memory model.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L = g + 1;
    mem_arbiter_if #(.AW(AW), .DW(DW)) sbus ();
    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(4)) u_sw (
      .clk(clk),
      .rst(rst),
      .bus(sbus.slave)
    );
    logic [AW-1:0] s_addr;
    int            s_cnt  = 0;
    bit            done_l = 1'b0;

    always begin
      @(posedge clk); #1;
      sbus.m_rdata = (s_cnt == 1) ? mem_read(s_addr) : GARBAGE;
      if (s_cnt > 0) s_cnt--;
      @(negedge clk);
      if (!rst && sbus.m_read) begin
        s_addr = sbus.m_addr;
        s_cnt  = L;
      end
    end

    initial begin
      int cyc;
      bit got;
      bit gnt_seen;
      logic [AW-1:0] a;
      sbus.if_req = 1'b0; sbus.if_addr = '0; sbus.d_req = 1'b0;
      sbus.d_we = 1'b0; sbus.d_addr = '0; sbus.d_wdata = '0;
      @(negedge rst);
      a = 32'h200 + 32'(g * 4);
      @(posedge clk); #1;
      sbus.d_req = 1'b1; sbus.d_addr = a;
      cyc = 1; got = 1'b0; gnt_seen = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (sbus.d_gnt) gnt_seen = 1'b1;
        if (sbus.d_rvalid) begin
          got = 1'b1;
          check($sformatf("sweep_lat%0d_cycles", L), 64'(cyc), 64'(L + 3));
          check($sformatf("sweep_lat%0d_data", L), 64'(sbus.d_rdata), 64'(mem_read(a)));
        end else begin
          @(posedge clk); #1;
          if (gnt_seen) sbus.d_req = 1'b0;
          cyc++;
        end
      end
      check($sformatf("sweep_lat%0d_rvalid_seen", L), 64'(got), 64'd1);
      done_l = 1'b1;
    end
  end

  typedef struct {
    bit            is_d;
    bit            we;
    bit            early;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_gnt;
    int            exp_end;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  g_c, e_c, ngnt;
    bit  seen;
    bit  rnd_d, rnd_we;

    vecs[0] = '{0, 0, 0, 32'h40,        32'h0,         2, LAT + 3};
    vecs[1] = '{1, 1, 0, 32'h100,       32'hDEADBEEF,  2, 3};
    vecs[2] = '{1, 0, 0, 32'h10,        32'h0,         2, LAT + 3};
    vecs[3] = '{0, 0, 0, 32'h20,        32'h0,         2, LAT + 3};
    vecs[4] = '{1, 1, 0, 32'h0,         32'hFFFF_FFFF, 2, 3};
    vecs[5] = '{1, 0, 0, 32'hFFFF_FFFC, 32'h0,         2, LAT + 3};
    vecs[6] = '{0, 0, 0, 32'hFFFF_FFFC, 32'h0,         2, LAT + 3};
    vecs[7] = '{0, 0, 1, 32'h60,        32'h0,         2, LAT + 3};
    vecs[8] = '{1, 1, 1, 32'h44,        32'h1,         2, 3};
    for (int i = 9; i < 12; i++) begin
      rnd_d  = 1'($urandom_range(0, 1));
      rnd_we = rnd_d & 1'($urandom_range(0, 1));
      vecs[i] = '{rnd_d, rnd_we, 0, $urandom() & 32'hFFFF_FFFC, $urandom(), 2,
                  rnd_we ? 3 : LAT + 3};
    end

    // Clock/reset
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single accesses
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].is_d, vecs[i].we, vecs[i].early, vecs[i].addr, vecs[i].wdata, g_c, e_c);
      check($sformatf("vec%0d_gnt_cycle", i), 64'(g_c), 64'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_end_cycle", i), 64'(e_c), 64'(vecs[i].exp_end));
    end

    // Both requesters held: fetch wins once after four data grants
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) exp_q.push_back({1'b0, mem_read(32'h300)});
      else              exp_q.push_back({1'b1, mem_read(32'h400)});
    end
    bus.if_addr = 32'h300; bus.d_addr = 32'h400; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    ngnt = 0;
    for (int k = 0; k < 200 && ngnt < 10; k++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.d_gnt) begin
        check($sformatf("order%0d_is_fetch", ngnt), 64'(bus.if_gnt), 64'((ngnt % 5) == 4));
        ngnt++;
      end
    end
    check("order_grant_count", 64'(ngnt), 64'd10);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    check("order_drained", 64'(exp_q.size()), 64'd0);

    for (int k = 0; k < 300 && !(g_sw[0].done_l && g_sw[1].done_l &&
                                 g_sw[2].done_l && g_sw[3].done_l); k++) @(posedge clk);
    check("sweep_done", 64'({g_sw[0].done_l, g_sw[1].done_l, g_sw[2].done_l, g_sw[3].done_l}), 64'hF);

    // Reset while a read sits in WAIT: access dropped, no rvalid
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.d_gnt) seen = 1'b1;
    end
    check("rst_wait_gnt_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_wait");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_wait_no_rvalid%0d", k), 64'(bus.if_rvalid | bus.d_rvalid), 64'd0);
    end
    do_req(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, g_c, e_c);
    check("after_rst_gnt_cycle", 64'(g_c), 64'd2);
    check("after_rst_end_cycle", 64'(e_c), 64'(LAT + 3));

    repeat (2) @(posedge clk);
    check("final_read_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_write_queue_empty", 64'(wexp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW 32, address width; DW 32, data width; MEM_LAT 1, memory read latency in cycles (legal 1..4); STARVE_MAX 4, number of consecutive data grants after which a waiting fetch wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-005 if_addr  input  AW  fetch address; held stable with if_req.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch access issued to memory.
REQ-007 if_rvalid  output  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  output  DW  fetched instruction word.
REQ-009 d_req  input  1  data request; held until d_gnt.
REQ-010 d_we  input  1  1 = write, 0 = read; stable with d_req.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  DW  write data.
REQ-013 d_gnt  output  1  one-cycle pulse: data access issued.
REQ-014 d_rvalid  output  1  one-cycle pulse: d_rdata valid (reads only).
REQ-015 d_rdata  output  DW  read data.
REQ-016 m_addr  output  AW  memory address.
REQ-017 m_wdata  output  DW  memory write data.
REQ-018 m_read  output  1  memory read strobe, one cycle.
REQ-019 m_write  output  1  memory write strobe, one cycle.
REQ-020 m_rdata  input  DW  memory read data, valid MEM_LAT cycles after the m_read cycle.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: if any request is present, the block SHALL latch the winner, its address, data and we, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-024 Priority: data SHALL win over fetch, except that fetch SHALL win when both requests are present and starve_cnt == STARVE_MAX.
REQ-025 ISSUE: the block SHALL drive m_addr/m_wdata from the latched values and pulse m_read or m_write for exactly one cycle, together with the winner's gnt.
REQ-026 ISSUE transitions: a write SHALL go to IDLE; a read SHALL go to WAIT.
REQ-027 WAIT: a latency counter SHALL run so that m_rdata is registered exactly MEM_LAT cycles after the ISSUE cycle, then the FSM SHALL go to RESP.
REQ-028 RESP: the block SHALL pulse the owner's rvalid with the registered data for one cycle, then go to IDLE.
REQ-029 Access time SHALL be 2 cycles for a write (IDLE, ISSUE) and MEM_LAT+3 cycles for a read (IDLE, ISSUE, WAIT×MEM_LAT, RESP), request to rvalid.
REQ-030 Only one access SHALL be outstanding at a time; requests are sampled only in IDLE.
REQ-031 starve_cnt SHALL be a saturating counter (0..STARVE_MAX) updated on data grants.
- It increments on each d_gnt while if_req is high.
- It clears on if_gnt, and on any cycle in IDLE with if_req low.
REQ-032 gnt, rvalid, m_read and m_write SHALL be registered outputs, and only one gnt SHALL be high in any cycle.
REQ-033 if_rdata/d_rdata SHALL hold their last value between rvalid pulses; m_read and m_write SHALL never be high together.
REQ-034 If a requester deasserts req after latching but before gnt, the latched access SHALL still be performed and acknowledged (protocol violation, deterministic outcome).

Reset
REQ-035 When rst is high at a clock edge, the block SHALL take the following values:
- state = IDLE, starve_cnt = 0, latency counter = 0.
- All gnt, rvalid, m_read, m_write and busy outputs = 0.
- m_addr, m_wdata, if_rdata and d_rdata = 0.
REQ-036 A reset during WAIT or RESP SHALL abort the access, with no rvalid pulse afterward.

Structure
REQ-037 FSM state encoding and the default MEM_LAT/STARVE_MAX values SHALL live in a shared package, mem_arb_pkg.
REQ-038 The priority and starvation logic SHALL be one sub-module, arb_prio (inputs if_req, d_req, starve_cnt; output sel_data).

Verification
REQ-039 Single fetch: if_req=1, if_addr=0x40, MEM_LAT=2, memory returns 0x8C020004 -> if_gnt in cycle 2, if_rvalid in cycle 5 with if_rdata=0x8C020004.
REQ-040 Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_write pulse in cycle 2 with m_addr=0x100 and m_wdata=0xDEADBEEF; busy low in cycle 3.
REQ-041 Simultaneous requests: if_req and d_req held continuously with d_we=0 -> grants in the order d,d,d,d,if,d,d,d,d,if.
REQ-042 Back-to-back reads: a data read to 0x10 then a fetch to 0x20 -> one m_read per access, never overlapping, each rvalid routed to the correct requester.
REQ-043 Reset during WAIT: rst pulsed while a read is outstanding -> no rvalid, busy=0 the next cycle, and the next request is served normally.
REQ-044 MEM_LAT sweep over 1..4 -> request-to-rvalid is MEM_LAT+3 cycles in every case.
